// File: rtl/control_contar_rango_if.sv
// Handshake/bus bundle for control_contar_rango: start/abort/ack controls in, count and status out.
// The pause signal exists only when CONTAR_RANGO_PAUSE_EN is defined.
interface control_contar_rango_if #(
  parameter int WIDTH = 24
);
  logic             init;
  logic [WIDTH-1:0] limit;
  logic             mode;
  logic             abort;
  logic             ack;
`ifdef CONTAR_RANGO_PAUSE_EN
  logic             pause;
`endif
  logic [WIDTH-1:0] count;
  logic             plus;
  logic             out_rst;
  logic             CN;
  logic             tick;

`ifdef CONTAR_RANGO_PAUSE_EN
  modport master (
    output init, limit, mode, abort, ack, pause,
    input  count, plus, out_rst, CN, tick
  );
  modport slave (
    input  init, limit, mode, abort, ack, pause,
    output count, plus, out_rst, CN, tick
  );
`else
  modport master (
    output init, limit, mode, abort, ack,
    input  count, plus, out_rst, CN, tick
  );
  modport slave (
    input  init, limit, mode, abort, ack,
    output count, plus, out_rst, CN, tick
  );
`endif
endinterface

// File: rtl/control_contar_rango.sv
// Range counter controller: IDLE/RUN/DONE FSM counting 0..limit in STEP increments, on the falling clock edge.
// Optional feature macro: CONTAR_RANGO_PAUSE_EN adds a pause input that freezes counting in RUN.
module control_contar_rango #(
  parameter int          WIDTH         = 24,
  parameter int unsigned STEP          = 1,
  parameter int unsigned DEFAULT_LIMIT = 12500000
) (
  input logic                  clk,
  input logic                  rst,
  control_contar_rango_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [WIDTH:0]   STEP_EXT  = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] LIMIT_RST = WIDTH'(DEFAULT_LIMIT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic             mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             pause_w;

  // Counter never wraps: an overflowing add pins at all-ones so the terminal compare still fires.
  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + STEP_EXT;
    return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  endfunction

`ifdef CONTAR_RANGO_PAUSE_EN
  assign pause_w = bus.pause;
`else
  assign pause_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    lim_d   = lim_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (bus.init && !bus.abort) begin
          lim_d   = bus.limit;
          mode_d  = bus.mode;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (!pause_w) begin
          if (count_q >= lim_q) begin
            tick_d = 1'b1;
            if (mode_q) count_d = '0;
            else        state_d = DONE;
          end else begin
            count_d = sat_add(count_q);
          end
        end
      end
      DONE: begin
        if (bus.abort || bus.ack) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Falling-edge state register
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      lim_q   <= LIMIT_RST;
      mode_q  <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      lim_q   <= lim_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.tick    = tick_q;
  assign bus.plus    = (state_q == RUN) && !pause_w;
  assign bus.out_rst = (state_q == IDLE);
  assign bus.CN      = (state_q == DONE);

endmodule

// File: tb/tb_control_contar_rango.sv
// Self-checking bench for control_contar_rango: vector table on a default-width instance plus
// hand-written sequences (saturation on an 8-bit STEP=100 instance, pause when enabled).
module tb_control_contar_rango;

  logic clk;
  logic rst;
  logic rst8;
  int   errors = 0;
  int   checks = 0;

  control_contar_rango_if #(.WIDTH(24)) ifs ();
  control_contar_rango_if #(.WIDTH(8))  ifs8 ();

  control_contar_rango #(.WIDTH(24), .STEP(1), .DEFAULT_LIMIT(12500000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifs)
  );

  control_contar_rango #(.WIDTH(8), .STEP(100), .DEFAULT_LIMIT(200)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (ifs8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  // Expected outputs packed as {count[23:0], plus, out_rst, CN, tick}
  typedef struct {
    logic        r;
    logic        init;
    logic [23:0] lim;
    logic        mode;
    logic        abort;
    logic        ack;
    logic [27:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [27:0] sb[$];

  function automatic vec_t mk(logic r, logic i, logic [23:0] l, logic m, logic a, logic k,
                              logic [23:0] c, logic p, logic o, logic n, logic t);
    vec_t v;
    v.r = r; v.init = i; v.lim = l; v.mode = m; v.abort = a; v.ack = k;
    v.exp = {c, p, o, n, t};
    return v;
  endfunction

  task automatic check(input string nm, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got count=%0d plus=%b out_rst=%b CN=%b tick=%b, expected count=%0d plus=%b out_rst=%b CN=%b tick=%b",
               nm, act[27:4], act[3], act[2], act[1], act[0],
               exp[27:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    logic [27:0] e;
    @(posedge clk);
    rst       = v.r;
    ifs.init  = v.init;
    ifs.limit = v.lim;
    ifs.mode  = v.mode;
    ifs.abort = v.abort;
    ifs.ack   = v.ack;
`ifdef CONTAR_RANGO_PAUSE_EN
    ifs.pause = 1'b0;
`endif
    sb.push_back(v.exp);
    @(negedge clk);
    #1;
    e = sb.pop_front();
    check(nm, {ifs.count, ifs.plus, ifs.out_rst, ifs.CN, ifs.tick}, e);
  endtask

  task automatic apply8(input logic r, input logic i, input logic [7:0] l, input logic a,
                        input logic k, input logic [27:0] exp, input string nm);
    logic [27:0] e;
    @(posedge clk);
    rst8       = r;
    ifs8.init  = i;
    ifs8.limit = l;
    ifs8.mode  = 1'b0;
    ifs8.abort = a;
    ifs8.ack   = k;
    sb.push_back(exp);
    @(negedge clk);
    #1;
    e = sb.pop_front();
    check(nm, {16'd0, ifs8.count, ifs8.plus, ifs8.out_rst, ifs8.CN, ifs8.tick}, e);
  endtask

`ifdef CONTAR_RANGO_PAUSE_EN
  task automatic apply_p(input logic i, input logic [23:0] l, input logic ps, input logic k,
                         input logic [27:0] exp, input string nm);
    logic [27:0] e;
    @(posedge clk);
    rst       = 1'b0;
    ifs.init  = i;
    ifs.limit = l;
    ifs.mode  = 1'b0;
    ifs.abort = 1'b0;
    ifs.ack   = k;
    ifs.pause = ps;
    sb.push_back(exp);
    @(negedge clk);
    #1;
    e = sb.pop_front();
    check(nm, {ifs.count, ifs.plus, ifs.out_rst, ifs.CN, ifs.tick}, e);
  endtask
`endif

  initial begin
    rst = 1'b1; rst8 = 1'b1;
    ifs.init = 0; ifs.limit = 0; ifs.mode = 0; ifs.abort = 0; ifs.ack = 0;
    ifs8.init = 0; ifs8.limit = 0; ifs8.mode = 0; ifs8.abort = 0; ifs8.ack = 0;
`ifdef CONTAR_RANGO_PAUSE_EN
    ifs.pause = 0;
    ifs8.pause = 0;
`endif

    // One-shot limit 5: reset, count 0..5, DONE holds (init ignored), ack releases
    vecs.push_back(mk(1,0,0,0,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,1,5,0,0,0, 0,1,0,0,0));
    for (int k = 1; k <= 5; k++) vecs.push_back(mk(0,0,5,0,0,0, 24'(k),1,0,0,0));
    vecs.push_back(mk(0,0,5,0,0,0, 5,0,0,1,1));
    vecs.push_back(mk(0,1,5,0,0,0, 5,0,0,1,0));
    vecs.push_back(mk(0,0,5,0,0,1, 0,0,1,0,0));
    vecs.push_back(mk(0,0,5,0,0,0, 0,0,1,0,0));
    // Continuous limit 3 for 12 cycles, then abort
    vecs.push_back(mk(0,1,3,1,0,0, 0,1,0,0,0));
    for (int c = 1; c <= 12; c++)
      vecs.push_back(mk(0,0,3,1,0,0, 24'(c % 4),1,0,0,((c % 4) == 0)));
    vecs.push_back(mk(0,0,3,1,1,0, 0,0,1,0,0));
    // limit/mode changed mid-run are ignored; init+abort in IDLE stays IDLE
    vecs.push_back(mk(0,1,5,0,0,0, 0,1,0,0,0));
    for (int k = 1; k <= 5; k++) vecs.push_back(mk(0,0,2,1,0,0, 24'(k),1,0,0,0));
    vecs.push_back(mk(0,0,2,1,0,0, 5,0,0,1,1));
    vecs.push_back(mk(0,0,2,1,0,1, 0,0,1,0,0));
    vecs.push_back(mk(0,1,7,0,1,0, 0,0,1,0,0));
    vecs.push_back(mk(0,1,7,0,1,0, 0,0,1,0,0));
    // abort at count 2 (outranks ack)
    vecs.push_back(mk(0,1,10,0,0,0, 0,1,0,0,0));
    vecs.push_back(mk(0,0,10,0,0,0, 1,1,0,0,0));
    vecs.push_back(mk(0,0,10,0,0,0, 2,1,0,0,0));
    vecs.push_back(mk(0,0,10,0,1,1, 0,0,1,0,0));
    // reset mid-run overrides init
    vecs.push_back(mk(0,1,10,0,0,0, 0,1,0,0,0));
    vecs.push_back(mk(0,0,10,0,0,0, 1,1,0,0,0));
    vecs.push_back(mk(0,0,10,0,0,0, 2,1,0,0,0));
    vecs.push_back(mk(1,1,10,1,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,0,10,0,0,0, 0,0,1,0,0));
    // limit 0 one-shot: abort outranks terminal detection
    vecs.push_back(mk(0,1,0,0,0,0, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,0,0));
    // limit 0 one-shot: one plus cycle then DONE, abort releases DONE
    vecs.push_back(mk(0,1,0,0,0,0, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,0, 0,0,0,1,1));
    vecs.push_back(mk(0,0,0,0,1,0, 0,0,1,0,0));
    // limit 0 continuous: terminal every edge
    vecs.push_back(mk(0,1,0,1,0,0, 0,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,0, 0,1,0,0,1));
    vecs.push_back(mk(0,0,0,1,0,0, 0,1,0,0,1));
    vecs.push_back(mk(0,0,0,1,1,0, 0,0,1,0,0));

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Saturation: WIDTH=8, STEP=100, limit 250 -> 0,100,200,255 then DONE
    apply8(1,0,0,  0,0, {24'd0,  4'b0100}, "sat_rst");
    apply8(0,1,250,0,0, {24'd0,  4'b1000}, "sat_c0");
    apply8(0,0,250,0,0, {24'd100,4'b1000}, "sat_c100");
    apply8(0,0,250,0,0, {24'd200,4'b1000}, "sat_c200");
    apply8(0,0,250,0,0, {24'd255,4'b1000}, "sat_c255");
    apply8(0,0,250,0,0, {24'd255,4'b0011}, "sat_done");
    apply8(0,0,250,0,0, {24'd255,4'b0010}, "sat_hold");
    apply8(0,0,250,0,1, {24'd0,  4'b0100}, "sat_ack");

`ifdef CONTAR_RANGO_PAUSE_EN
    // Pause 3 cycles at count 2 of limit 4: DONE arrives 3 edges late
    apply_p(1,4,0,0, {24'd0,4'b1000}, "pz_c0");
    apply_p(0,4,0,0, {24'd1,4'b1000}, "pz_c1");
    apply_p(0,4,0,0, {24'd2,4'b1000}, "pz_c2");
    for (int k = 0; k < 3; k++) apply_p(0,4,1,0, {24'd2,4'b0000}, "pz_hold");
    apply_p(0,4,0,0, {24'd3,4'b1000}, "pz_c3");
    apply_p(0,4,0,0, {24'd4,4'b1000}, "pz_c4");
    apply_p(0,4,0,0, {24'd4,4'b0011}, "pz_done");
    apply_p(0,4,1,1, {24'd0,4'b0100}, "pz_ack");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_contar_rango.md
CONTROL_CONTAR_RANGO -- requirements
Module: control_contar_rango

Interface
REQ-001 Parameter WIDTH, default 24: counter, limit and count width.
REQ-002 Parameter STEP, default 1: increment per active edge, range 1..2^WIDTH-1.
REQ-003 Parameter DEFAULT_LIMIT, default 12500000: reset value of the latched limit.
REQ-004 Port clk  input  1: single clock.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port init  input  1: start request, level-sampled in IDLE.
REQ-007 Port limit  input  WIDTH: terminal count, latched on start.
REQ-008 Port mode  input  1: 0 = one-shot, 1 = continuous; latched on start.
REQ-009 Port abort  input  1: return to IDLE from any state.
REQ-010 Port ack  input  1: releases DONE.
REQ-011 Port pause  input  1: freezes counting; present only with CONTAR_RANGO_PAUSE_EN.
REQ-012 Port count  output  WIDTH: current counter value.
REQ-013 Port plus  output  1: counting active this cycle.
REQ-014 Port out_rst  output  1: downstream clear, high in IDLE.
REQ-015 Port CN  output  1: count complete, high in DONE.
REQ-016 Port tick  output  1: one-cycle pulse per limit reached.

Function
REQ-017 State, count, latched limit and tick SHALL update on the falling edge of clk only.
REQ-018 States SHALL be IDLE, RUN, DONE; any unencoded state SHALL go to IDLE on the next edge.
REQ-019 Outputs plus, out_rst and CN SHALL be decoded from state: IDLE -> out_rst=1; RUN -> plus=1 (gated by pause); DONE -> CN=1; all others 0.
REQ-020 IDLE, init=1, abort=0: latch limit and mode, count=0, enter RUN on that edge.
REQ-021 RUN, count >= latched limit, one-shot: enter DONE, count holds, tick=1 for one cycle.
REQ-022 RUN, count >= latched limit, continuous: stay RUN, count=0, tick=1 for one cycle.
REQ-023 RUN, count < latched limit: count = count + STEP, saturating at all-ones (no wrap).
REQ-024 Latency, STEP=1, limit L: RUN entered at edge E0 with count 0; count=k at E0+k; DONE (or reload to 0) at E0+L+1; plus high L+1 cycles.
REQ-025 limit=0 at start: first RUN edge SHALL hit terminal (one cycle of plus, then DONE/reload).
REQ-026 limit and mode changes during RUN/DONE SHALL be ignored until the next start.
REQ-027 DONE SHALL hold (CN=1, count held) until ack=1 -> IDLE, count=0.
REQ-028 abort=1 in RUN or DONE SHALL force IDLE and count=0 on that edge; abort outranks init, ack, pause and terminal detection.
REQ-029 abort=1 and init=1 together in IDLE: remain IDLE.
REQ-030 tick SHALL be 0 on every edge not covered by REQ-021/REQ-022.

Reset
REQ-031 rst=1 at a falling edge: state=IDLE, count=0, tick=0, latched limit=DEFAULT_LIMIT, latched mode=0; overrides all inputs, including mid-RUN.
REQ-032 After reset: out_rst=1, plus=0, CN=0 until a start is accepted.

Configuration
REQ-033 With CONTAR_RANGO_PAUSE_EN defined: port pause exists; pause=1 in RUN holds count, suppresses terminal detection and tick, and forces plus=0; pause is ignored in IDLE/DONE.
REQ-034 Without CONTAR_RANGO_PAUSE_EN: no pause port; RUN counts every edge.

Verification
REQ-035 rst, then init=1, limit=5, mode=0: count 0..5, plus high 6 cycles, tick once, CN=1 and count=5 held; ack=1 -> IDLE, out_rst=1.
REQ-036 limit=3, mode=1, run 12 cycles: count sequence 0,1,2,3,0,1,2,3,...; tick on each 3->0 edge; CN stays 0.
REQ-037 WIDTH=8, STEP=100, limit=250: count 0,100,200,255 (saturated), then DONE; no wrap to a small value.
REQ-038 abort=1 at count=2 of limit 10: IDLE and count=0 on that edge; rst=1 mid-RUN: same result, latched limit reset to DEFAULT_LIMIT.
REQ-039 PAUSE_EN, limit=4, pause=1 for 3 cycles at count=2: count holds 2, plus=0; release -> DONE reached 3 cycles later than unpaused.
REQ-040 limit changed from 5 to 2 mid-RUN and init=1 with abort=1 in IDLE: run still ends at 5; simultaneous case stays IDLE.
